// File: rtl/one_to_four_dispatch.sv
// Purpose : registered 1-to-4 demux; each lane is a one-entry slot (data register + full flag).
// Latency : a word accepted at edge N is visible on its lane after edge N (one cycle).
// Backpressure: in_ready is the free state of the targeted lane(s); a stalled lane never blocks the others.
//
// Ports:
//   clk, rst                clock and asynchronous active-high reset
//   in_data/in_sel/in_valid producer word, destination lane and offer; in_ready = accept this cycle
//   in_bcast                broadcast request (only when DISPATCH_BCAST_EN is defined)
//   out_data0..3            lane data registers (hold last value, zero after reset)
//   out_valid[3:0]          lane full flags; out_ready[3:0] consumer takes the word
//
// Optional feature macro: DISPATCH_BCAST_EN adds in_bcast and the all-lanes write path.
module one_to_four_dispatch #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
`ifdef DISPATCH_BCAST_EN
    input  logic             in_bcast,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready
);

    logic [WIDTH-1:0] slot_dat [4];
    logic [3:0]       lane_free;
    logic [3:0]       sel_onehot;
    logic [3:0]       lane_load;
    logic             accept;

    // A lane can take a new word if it is empty or its current word leaves this edge.
    assign lane_free = ~out_valid | out_ready;

    always_comb begin
        sel_onehot = 4'b0000;
        sel_onehot[in_sel] = 1'b1;
    end

`ifdef DISPATCH_BCAST_EN
    // Broadcast needs every lane free at once; in_sel is ignored in that mode.
    assign in_ready  = in_bcast ? (&lane_free) : |(lane_free & sel_onehot);
    assign accept    = in_valid && in_ready;
    assign lane_load = accept ? (in_bcast ? 4'b1111 : sel_onehot) : 4'b0000;
`else
    assign in_ready  = |(lane_free & sel_onehot);
    assign accept    = in_valid && in_ready;
    assign lane_load = accept ? sel_onehot : 4'b0000;
`endif

    for (genvar k = 0; k < 4; k++) begin : g_lane
        // Load has priority over drain so a same-edge drain+reload keeps the lane full.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_valid[k] <= 1'b0;
                slot_dat[k]  <= '0;
            end else if (lane_load[k]) begin
                out_valid[k] <= 1'b1;
                slot_dat[k]  <= in_data;
            end else if (out_ready[k]) begin
                out_valid[k] <= 1'b0;
            end
        end
    end

    assign out_data0 = slot_dat[0];
    assign out_data1 = slot_dat[1];
    assign out_data2 = slot_dat[2];
    assign out_data3 = slot_dat[3];

endmodule

// File: tb/tb_one_to_four_dispatch.sv
// Purpose : bench for one_to_four_dispatch with a per-lane scoreboard and a separate pop monitor.
// Latency : expectations follow the one-cycle accept-to-visible rule.
// Backpressure: random out_ready stalls; producer holds its offer until accepted.
module tb_one_to_four_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic        in_bcast;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;

    logic [31:0] od [4];
    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    one_to_four_dispatch #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
`ifdef DISPATCH_BCAST_EN
        .in_bcast  (in_bcast),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: words in flight per lane, whether each lane holds a word,
    // and the last word written into each lane's data register.
    logic [31:0] sbq [4][$];
    logic [3:0]  occ;
    logic [31:0] last [4];
    logic        last_acc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        occ = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            sbq[k].delete();
            last[k] = 32'h0;
        end
    endtask

    // One producer/consumer cycle: drive after the falling edge, check lane state and
    // in_ready against the model, then advance the model to what the next rising edge does.
    task automatic cycle(input logic v, input logic [1:0] s, input logic [31:0] d,
                         input logic [3:0] ordy, input logic b);
        logic [3:0] fr;
        logic       er;
        logic       ld;
        @(negedge clk);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = ordy;
        in_bcast  = b;
        #2;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("valid%0d", k), {31'b0, out_valid[k]}, {31'b0, occ[k]});
            chk($sformatf("data%0d", k), od[k], last[k]);
        end
        fr = ~occ | ordy;
        er = b ? (fr == 4'b1111) : fr[s];
        chk("in_ready", {31'b0, in_ready}, {31'b0, er});
        last_acc = v && er;
        for (int k = 0; k < 4; k++) begin
            ld = last_acc && (b || (s == k[1:0]));
            if (ld) begin
                sbq[k].push_back(d);
                last[k] = d;
            end
            occ[k] = ld || (occ[k] && !ordy[k]);
        end
    endtask

    // Consumer monitor: every completed lane handshake must deliver the oldest word sent there.
    always begin
        @(negedge clk);
        #3;
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (sbq[k].size() == 0) begin
                        chk($sformatf("spurious%0d", k), {31'b0, out_valid[k]}, 32'h0);
                    end else begin
                        chk($sformatf("pop%0d", k), od[k], sbq[k].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        logic        v;
        logic [1:0]  s;
        logic [31:0] d;
        logic        pend;
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = 32'h0;
        in_bcast = 1'b0; out_ready = 4'b0000;
        model_clear();
        #1;
        chk("reset_valid", {28'b0, out_valid}, 32'h0);
        for (int k = 0; k < 4; k++) chk($sformatf("reset_data%0d", k), od[k], 32'h0);
        @(negedge clk);
        #1 rst = 1'b0;

        // Back-pressure isolation: lane 2 stalled, lane 0 still accepted.
        cycle(1'b1, 2'd2, 32'h22, 4'b0000, 1'b0);
        cycle(1'b1, 2'd2, 32'h33, 4'b0000, 1'b0);
        cycle(1'b1, 2'd0, 32'h11, 4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 32'h0,  4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 32'h0,  4'b1111, 1'b0);

        // Full-throughput drain/reload on lane 1.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 2'd1, i, 4'b1111, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 4'b1111, 1'b0);

        // Same-edge drain of A and load of B on lane 0.
        cycle(1'b1, 2'd0, 32'hAAAA_0000, 4'b0000, 1'b0);
        cycle(1'b1, 2'd0, 32'hBBBB_0000, 4'b0001, 1'b0);
        cycle(1'b0, 2'd0, 32'h0,         4'b0001, 1'b0);

        // Per-lane independence: fill all, drain in order 3,1,0,2.
        for (int k = 0; k < 4; k++) cycle(1'b1, k[1:0], 32'hA0 + k, 4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 4'b1000, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 4'b0010, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 4'b0001, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 4'b0100, 1'b0);
        cycle(1'b0, 2'd0, 32'h0, 4'b0000, 1'b0);

`ifdef DISPATCH_BCAST_EN
        // Broadcast into empty lanes, then with lane 1 stalled until it drains.
        cycle(1'b1, 2'd2, 32'h5A5A5A5A, 4'b0000, 1'b1);
        cycle(1'b0, 2'd0, 32'h0,        4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 32'h0,        4'b1111, 1'b0);
        cycle(1'b1, 2'd1, 32'h77,       4'b0000, 1'b0);
        cycle(1'b1, 2'd0, 32'hC3C3C3C3, 4'b0000, 1'b1);
        cycle(1'b1, 2'd0, 32'hC3C3C3C3, 4'b0000, 1'b1);
        cycle(1'b1, 2'd0, 32'hC3C3C3C3, 4'b0010, 1'b1);
        cycle(1'b0, 2'd0, 32'h0,        4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 32'h0,        4'b1111, 1'b0);
`endif

        // Randomized traffic; an unaccepted offer is held stable.
        pend = 1'b0;
        v = 1'b0; s = 2'd0; d = 32'h0;
        for (int i = 0; i < 600; i++) begin
            logic b;
            logic [3:0] r;
            if (!pend) begin
                v = ($urandom_range(0, 3) != 0);
                s = 2'($urandom_range(0, 3));
                d = $urandom;
            end
            r = 4'($urandom);
            b = 1'b0;
`ifdef DISPATCH_BCAST_EN
            if (!pend) b = ($urandom_range(0, 7) == 0);
`endif
            cycle(v, s, d, r, b);
            pend = v && !last_acc;
        end
        pend = 1'b0;

        // Asynchronous reset mid-stream with lanes 1 and 3 full.
        cycle(1'b0, 2'd0, 32'h0,  4'b1111, 1'b0);
        cycle(1'b1, 2'd1, 32'h91, 4'b0000, 1'b0);
        cycle(1'b1, 2'd3, 32'h93, 4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 32'h0,  4'b0000, 1'b0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_valid", {28'b0, out_valid}, 32'h0);
        for (int k = 0; k < 4; k++) chk($sformatf("midrst_data%0d", k), od[k], 32'h0);
        in_sel = 2'd3;
        #0;
        chk("midrst_ready", {31'b0, in_ready}, 32'h1);
        model_clear();
        #1 rst = 1'b0;
        cycle(1'b1, 2'd3, 32'hDEADBEEF, 4'b0000, 1'b0);
        cycle(1'b0, 2'd0, 32'h0,        4'b0000, 1'b0);
        chk("post_rst_valid", {28'b0, out_valid}, 32'h8);
        chk("post_rst_data3", out_data3, 32'hDEADBEEF);
        cycle(1'b0, 2'd0, 32'h0,        4'b1111, 1'b0);
        cycle(1'b0, 2'd0, 32'h0,        4'b0000, 1'b0);

        for (int k = 0; k < 4; k++) chk($sformatf("leftover%0d", k), sbq[k].size(), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
